// File: rtl/im_pkg.sv
// Shared constants, state encoding and PC-to-word helper for the instruction-memory loader.
// Pure declarations: no latency, no flow control.
package im_pkg;

   localparam int IM_DEPTH = 32;
   localparam int IM_AW    = 5;
   localparam int IM_DW    = 32;

   localparam logic [IM_DW-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FILL,
      ST_RESTART,
      ST_RUN,
      ST_FAULT
   } ld_state_t;

   // Byte PC to word index; the two alignment bits are shifted away.
   function automatic logic [IM_AW-1:0] pc_to_index(input logic [IM_AW+1:0] pc);
      return IM_AW'(pc >> 2);
   endfunction

endpackage

// File: rtl/im_fetch_check.sv
// Combinational fetch decode: CPU byte PC to IM word index plus out-of-image/misalignment flag.
// Zero latency, no flow control.
module im_fetch_check
   import im_pkg::*;
#(
   parameter int DEPTH = IM_DEPTH,
   parameter int AW    = IM_AW
) (
   input  logic [31:0]   cpu_pc,
   output logic [AW-1:0] idx,
   output logic          fault
);

   localparam logic [31:0] PC_LIMIT = 32'(4 * DEPTH);

   always_comb begin
      idx   = AW'(pc_to_index(cpu_pc[IM_AW+1:0]));
      fault = (cpu_pc[1:0] != 2'b00) || (cpu_pc >= PC_LIMIT);
   end

endmodule

// File: rtl/im_load_ctrl.sv
// Loads a host program into IM, NOP-fills the tail, restarts the CPU and guards fetches.
// All outputs registered (one cycle after the deciding input); host backpressure via ld_ready.
module im_load_ctrl
   import im_pkg::*;
#(
   parameter int DEPTH = IM_DEPTH,
   parameter int AW    = IM_AW,
   parameter int DW    = IM_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          ld_valid,
   input  logic          ld_last,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          im_we,
   output logic [AW-1:0] im_waddr,
   output logic [DW-1:0] im_wdata,
   output logic [AW-1:0] im_raddr,
   input  logic [31:0]   cpu_pc,
   output logic          cpu_stall,
   output logic          cpu_restart,
   output logic [AW:0]   prog_len,
   output logic          fetch_fault,
   output logic          busy
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL_LEN = (AW + 1)'(DEPTH);

   ld_state_t     state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   prog_len_q, prog_len_d;
   logic          ld_ready_q, ld_ready_d;
   logic          im_we_q, im_we_d;
   logic [AW-1:0] im_waddr_q, im_waddr_d;
   logic [DW-1:0] im_wdata_q, im_wdata_d;
   logic [AW-1:0] im_raddr_q, im_raddr_d;
   logic          cpu_stall_q, cpu_stall_d;
   logic          cpu_restart_q, cpu_restart_d;
   logic          fetch_fault_q, fetch_fault_d;
   logic          busy_q, busy_d;

   logic          go_load;
   logic [AW-1:0] wptr_inc;
   logic [AW-1:0] fc_idx;
   logic          fc_fault;

   im_fetch_check #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fetch_check (
      .cpu_pc (cpu_pc),
      .idx    (fc_idx),
      .fault  (fc_fault)
   );

   always_comb begin
      state_d       = state_q;
      wptr_d        = wptr_q;
      prog_len_d    = prog_len_q;
      ld_ready_d    = ld_ready_q;
      im_we_d       = 1'b0;
      im_waddr_d    = im_waddr_q;
      im_wdata_d    = im_wdata_q;
      im_raddr_d    = im_raddr_q;
      cpu_restart_d = 1'b0;
      fetch_fault_d = fetch_fault_q;
      go_load       = 1'b0;
      wptr_inc      = (wptr_q == LAST_IDX) ? wptr_q : wptr_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            go_load = load_start;
         end

         ST_LOAD: begin
            if (ld_ready_q) begin
               if (ld_valid) begin
                  im_we_d    = 1'b1;
                  im_waddr_d = wptr_q;
                  im_wdata_d = ld_data;
                  wptr_d     = wptr_inc;
                  prog_len_d = (prog_len_q == FULL_LEN) ? prog_len_q : prog_len_q + 1'b1;
                  if (ld_last || (wptr_q == LAST_IDX)) begin
                     ld_ready_d = 1'b0;
                  end
               end
            end else if (prog_len_q == FULL_LEN) begin
               // Image filled IM completely; the final host write is on the bus now.
               state_d       = ST_RESTART;
               cpu_restart_d = 1'b1;
               fetch_fault_d = 1'b0;
            end else begin
               state_d    = ST_FILL;
               im_we_d    = 1'b1;
               im_waddr_d = wptr_q;
               im_wdata_d = NOP_WORD;
               wptr_d     = wptr_inc;
            end
         end

         ST_FILL: begin
            // Leave only once the top word's write is visible, so RESTART sees im_we low.
            if (im_we_q && (im_waddr_q == LAST_IDX)) begin
               state_d       = ST_RESTART;
               cpu_restart_d = 1'b1;
               fetch_fault_d = 1'b0;
            end else begin
               im_we_d    = 1'b1;
               im_waddr_d = wptr_q;
               im_wdata_d = NOP_WORD;
               wptr_d     = wptr_inc;
            end
         end

         ST_RESTART: begin
            state_d = ST_RUN;
         end

         ST_RUN: begin
            im_raddr_d = fc_idx;
            if (load_start) begin
               go_load = 1'b1;
            end else if (fc_fault) begin
               state_d       = ST_FAULT;
               fetch_fault_d = 1'b1;
            end
         end

         ST_FAULT: begin
            go_load = load_start;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (go_load) begin
         state_d    = ST_LOAD;
         wptr_d     = '0;
         prog_len_d = '0;
         ld_ready_d = 1'b1;
      end

      cpu_stall_d = (state_d != ST_RUN);
      busy_d      = (state_d == ST_LOAD) || (state_d == ST_FILL) || (state_d == ST_RESTART);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         wptr_q        <= '0;
         prog_len_q    <= '0;
         ld_ready_q    <= 1'b0;
         im_we_q       <= 1'b0;
         im_waddr_q    <= '0;
         im_wdata_q    <= '0;
         im_raddr_q    <= '0;
         cpu_stall_q   <= 1'b1;
         cpu_restart_q <= 1'b0;
         fetch_fault_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wptr_q        <= wptr_d;
         prog_len_q    <= prog_len_d;
         ld_ready_q    <= ld_ready_d;
         im_we_q       <= im_we_d;
         im_waddr_q    <= im_waddr_d;
         im_wdata_q    <= im_wdata_d;
         im_raddr_q    <= im_raddr_d;
         cpu_stall_q   <= cpu_stall_d;
         cpu_restart_q <= cpu_restart_d;
         fetch_fault_q <= fetch_fault_d;
         busy_q        <= busy_d;
      end
   end

   assign ld_ready    = ld_ready_q;
   assign im_we       = im_we_q;
   assign im_waddr    = im_waddr_q;
   assign im_wdata    = im_wdata_q;
   assign im_raddr    = im_raddr_q;
   assign cpu_stall   = cpu_stall_q;
   assign cpu_restart = cpu_restart_q;
   assign prog_len    = prog_len_q;
   assign fetch_fault = fetch_fault_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_im_load_ctrl.sv
// Bench for im_load_ctrl: scoreboarded IM writes, restart pulse, fetch mapping and fault handling.
module tb_im_load_ctrl;
   import im_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        load_start;
   logic        ld_valid;
   logic        ld_last;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        im_we;
   logic [4:0]  im_waddr;
   logic [31:0] im_wdata;
   logic [4:0]  im_raddr;
   logic [31:0] cpu_pc;
   logic        cpu_stall;
   logic        cpu_restart;
   logic [5:0]  prog_len;
   logic        fetch_fault;
   logic        busy;

   im_load_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .ld_valid    (ld_valid),
      .ld_last     (ld_last),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .im_we       (im_we),
      .im_waddr    (im_waddr),
      .im_wdata    (im_wdata),
      .im_raddr    (im_raddr),
      .cpu_pc      (cpu_pc),
      .cpu_stall   (cpu_stall),
      .cpu_restart (cpu_restart),
      .prog_len    (prog_len),
      .fetch_fault (fetch_fault),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          w31_cyc = -100;
   int          rs_cnt = 0;
   int          wr_cnt = 0;
   logic [36:0] exp_q[$];
   logic [36:0] exp_e;
   logic [31:0] prog[32];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Write scoreboard and restart-pulse monitor.
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            chk("spurious_write", 64'(im_we), 64'd0);
         end else begin
            exp_e = exp_q.pop_front();
            chk("waddr", 64'(im_waddr), 64'(exp_e[36:32]));
            chk("wdata", 64'(im_wdata), 64'(exp_e[31:0]));
         end
         if (im_waddr == 5'd31) w31_cyc = cyc;
      end
      if (cpu_restart === 1'b1) begin
         rs_cnt++;
         chk("restart_after_top_write", 64'(cyc - w31_cyc), 64'd1);
         chk("restart_we_low", 64'(im_we), 64'd0);
         chk("restart_stall", 64'(cpu_stall), 64'd1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_words(input int n, input bit use_last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int w;
         ld_valid = 1'b1;
         ld_data  = prog[i];
         ld_last  = use_last && (i == n - 1);
         w = 0;
         while (ld_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
         end
         if (w >= 40) chk("ld_ready_timeout", 64'(ld_ready), 64'd1);
         exp_q.push_back({5'(i), prog[i]});
         tick();
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         if (gaps) tick();
      end
   endtask

   task automatic push_fill(input int n);
      for (int i = n; i < 32; i++) exp_q.push_back({5'(i), NOP_WORD});
   endtask

   task automatic wait_restart(input int len);
      int w;
      w = 0;
      @(negedge clk);
      while (cpu_restart !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("restart_seen", 64'(cpu_restart), 64'd1);
      chk("rs_prog_len", 64'(prog_len), 64'(len));
      chk("rs_fault_clear", 64'(fetch_fault), 64'd0);
      chk("rs_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("run_stall", 64'(cpu_stall), 64'd0);
      chk("run_busy", 64'(busy), 64'd0);
      chk("run_restart_low", 64'(cpu_restart), 64'd0);
      chk("run_prog_len", 64'(prog_len), 64'(len));
      chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b1;
      ld_valid   = 1'b0;
      ld_last    = 1'b0;
      ld_data    = '0;
      cpu_pc     = '0;

      // Reset held with load_start asserted.
      repeat (3) tick();
      chk("rst_ld_ready", 64'(ld_ready), 64'd0);
      chk("rst_im_we", 64'(im_we), 64'd0);
      chk("rst_im_waddr", 64'(im_waddr), 64'd0);
      chk("rst_im_wdata", 64'(im_wdata), 64'd0);
      chk("rst_im_raddr", 64'(im_raddr), 64'd0);
      chk("rst_cpu_stall", 64'(cpu_stall), 64'd1);
      chk("rst_cpu_restart", 64'(cpu_restart), 64'd0);
      chk("rst_prog_len", 64'(prog_len), 64'd0);
      chk("rst_fetch_fault", 64'(fetch_fault), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      load_start = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("idle_ld_ready", 64'(ld_ready), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_stall", 64'(cpu_stall), 64'd1);

      // Short program, ld_last on word 3.
      prog[0] = 32'h2001_0005;
      prog[1] = 32'h2002_0003;
      prog[2] = 32'h0022_1820;
      prog[3] = 32'hAC03_0000;
      rs_cnt = 0;
      start_load();
      chk("load_ld_ready", 64'(ld_ready), 64'd1);
      chk("load_busy", 64'(busy), 64'd1);
      chk("load_prog_len0", 64'(prog_len), 64'd0);
      send_words(4, 1'b1, 1'b0);
      chk("short_ready_drop", 64'(ld_ready), 64'd0);
      push_fill(4);
      wait_restart(4);
      repeat (3) tick();
      chk("short_restart_once", 64'(rs_cnt), 64'd1);

      // Fetch mapping, top boundary, then out-of-range fault.
      cpu_pc = 32'h0000_000C;
      tick();
      chk("raddr_0x0c", 64'(im_raddr), 64'd3);
      chk("no_fault_0x0c", 64'(fetch_fault), 64'd0);
      cpu_pc = 32'h0000_007C;
      tick();
      chk("raddr_0x7c", 64'(im_raddr), 64'd31);
      chk("no_fault_0x7c", 64'(fetch_fault), 64'd0);
      chk("run_stall_0x7c", 64'(cpu_stall), 64'd0);
      cpu_pc = 32'h0000_0080;
      tick();
      chk("fault_0x80", 64'(fetch_fault), 64'd1);
      chk("fault_stall", 64'(cpu_stall), 64'd1);
      chk("fault_busy", 64'(busy), 64'd0);
      cpu_pc = 32'h0000_0000;
      repeat (2) tick();
      chk("fault_sticky", 64'(fetch_fault), 64'd1);
      chk("fault_stall_held", 64'(cpu_stall), 64'd1);

      // Reload from FAULT with a one-word program.
      prog[0] = 32'h2001_0007;
      rs_cnt = 0;
      start_load();
      chk("reload_ready", 64'(ld_ready), 64'd1);
      chk("reload_fault_held", 64'(fetch_fault), 64'd1);
      send_words(1, 1'b1, 1'b0);
      push_fill(1);
      wait_restart(1);
      chk("reload_restart_once", 64'(rs_cnt), 64'd1);
      cpu_pc = 32'h0000_0006;
      tick();
      chk("fault_misaligned", 64'(fetch_fault), 64'd1);
      chk("misaligned_stall", 64'(cpu_stall), 64'd1);

      // Full 32-word image with gaps on ld_valid, no ld_last.
      for (int i = 0; i < 32; i++) prog[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
      cpu_pc = 32'h0000_0000;
      rs_cnt = 0;
      start_load();
      wr_cnt = 0;
      send_words(32, 1'b0, 1'b1);
      chk("full_ready_drop", 64'(ld_ready), 64'd0);
      ld_valid = 1'b1;
      ld_data  = 32'hDEAD_BEEF;
      wait_restart(32);
      ld_valid = 1'b0;
      repeat (2) tick();
      chk("full_write_count", 64'(wr_cnt), 64'd32);
      chk("full_restart_once", 64'(rs_cnt), 64'd1);

      // load_start wins over a simultaneous fetch fault.
      cpu_pc     = 32'h0000_0081;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      cpu_pc     = 32'h0000_0000;
      chk("prio_no_fault", 64'(fetch_fault), 64'd0);
      chk("prio_ready", 64'(ld_ready), 64'd1);
      chk("prio_stall", 64'(cpu_stall), 64'd1);
      chk("prio_busy", 64'(busy), 64'd1);

      // Reset right after word 10 is accepted.
      for (int i = 0; i < 11; i++) prog[i] = 32'h3000_0000 | 32'(i);
      send_words(11, 1'b0, 1'b0);
      chk("pre_rst_prog_len", 64'(prog_len), 64'd11);
      rst_n = 1'b0;
      tick();
      chk("midrst_im_we", 64'(im_we), 64'd0);
      chk("midrst_prog_len", 64'(prog_len), 64'd0);
      chk("midrst_ld_ready", 64'(ld_ready), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_stall", 64'(cpu_stall), 64'd1);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("abandoned_ready", 64'(ld_ready), 64'd0);
      chk("abandoned_busy", 64'(busy), 64'd0);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
